if_id_skid_reg: RTL and testbench

//  Parametrised IF->ID pipeline register with valid/ready handshake on both sides.

---
 rtl/if_id_skid_reg_if.sv | 28 ++
 rtl/if_id_skid_reg.sv | 167 ++++++++++++++++
 tb/tb_if_id_skid_reg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_reg_if.sv
// IF->ID handshake bundle: fetch-side beat plus flush/stall in, decode-side beat out.
// master = environment (fetch + hazard unit + decode), slave = the pipeline register.
interface if_id_skid_reg_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] InstrF;
   logic [ADDR_WIDTH-1:0] PCF;
   logic [ADDR_WIDTH-1:0] PCPlus4F;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] InstrD;
   logic [ADDR_WIDTH-1:0] PCD;
   logic [ADDR_WIDTH-1:0] PCPlus4D;

   modport master (
      output in_valid, InstrF, PCF, PCPlus4F, flush, out_ready,
      input  in_ready, out_valid, InstrD, PCD, PCPlus4D
   );

   modport slave (
      input  in_valid, InstrF, PCF, PCPlus4F, flush, out_ready,
      output in_ready, out_valid, InstrD, PCD, PCPlus4D
   );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer, stall, flush-to-NOP and async reset.
// Optional saturating stall/flush counters are built when IFID_PERF_CNT_EN is defined.
module if_id_skid_reg #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013,
   parameter int                    CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   if_id_skid_reg_if.slave      bus
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_IN   = 2'd1,
      SEL_SKID = 2'd2,
      SEL_NOP  = 2'd3
   } main_sel_t;

   state_t                r_state;
   state_t                w_state_nxt;
   main_sel_t             w_main_sel;
   logic                  w_in_ready;
   logic                  w_out_valid;
   logic                  w_accept;
   logic                  w_consume;
   logic                  w_skid_load;
   logic                  w_skid_clr;

   logic [DATA_WIDTH-1:0] r_main_instr;
   logic [ADDR_WIDTH-1:0] r_main_pc;
   logic [ADDR_WIDTH-1:0] r_main_pc4;
   logic [DATA_WIDTH-1:0] r_skid_instr;
   logic [ADDR_WIDTH-1:0] r_skid_pc;
   logic [ADDR_WIDTH-1:0] r_skid_pc4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.flush) begin
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
            S_ONE: begin
               if (w_accept && !w_consume)      w_state_nxt = S_FULL;
               else if (!w_accept && w_consume) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_consume) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // Handshake depends on state only, so in_ready never combinationally follows out_ready.
   always_comb begin
      w_in_ready  = (r_state != S_FULL);
      w_out_valid = (r_state != S_EMPTY);
      w_accept    = bus.in_valid & w_in_ready;
      w_consume   = w_out_valid & bus.out_ready;
      w_main_sel  = SEL_HOLD;
      w_skid_load = 1'b0;
      w_skid_clr  = 1'b0;
      if (bus.flush) begin
         w_main_sel = SEL_NOP;
         w_skid_clr = 1'b1;
      end else begin
         case (r_state)
            S_EMPTY: if (w_accept) w_main_sel = SEL_IN;
            S_ONE: begin
               if (w_accept && w_consume)       w_main_sel  = SEL_IN;
               else if (w_accept)               w_skid_load = 1'b1;
               else if (w_consume)              w_main_sel  = SEL_NOP;
            end
            S_FULL: begin
               if (w_consume) begin
                  w_main_sel = SEL_SKID;
                  w_skid_clr = 1'b1;
               end
            end
            default: w_main_sel = SEL_NOP;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.InstrD    = r_main_instr;
   assign bus.PCD       = r_main_pc;
   assign bus.PCPlus4D  = r_main_pc4;

   // The main entry is loaded with the NOP bubble whenever it empties, so outputs need no gating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_instr <= NOP_INSTR;
         r_main_pc    <= '0;
         r_main_pc4   <= '0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_skid_pc4   <= '0;
      end else begin
         case (w_main_sel)
            SEL_IN: begin
               r_main_instr <= bus.InstrF;
               r_main_pc    <= bus.PCF;
               r_main_pc4   <= bus.PCPlus4F;
            end
            SEL_SKID: begin
               r_main_instr <= r_skid_instr;
               r_main_pc    <= r_skid_pc;
               r_main_pc4   <= r_skid_pc4;
            end
            SEL_NOP: begin
               r_main_instr <= NOP_INSTR;
               r_main_pc    <= '0;
               r_main_pc4   <= '0;
            end
            default: ;
         endcase
         if (w_skid_load) begin
            r_skid_instr <= bus.InstrF;
            r_skid_pc    <= bus.PCF;
            r_skid_pc4   <= bus.PCPlus4F;
         end else if (w_skid_clr) begin
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_skid_pc4   <= '0;
         end
      end
   end

`ifdef IFID_PERF_CNT_EN
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (w_out_valid && !bus.out_ready && !bus.flush) stall_cnt <= sat_inc(stall_cnt);
         if (bus.flush && (r_state != S_EMPTY))            flush_cnt <= sat_inc(flush_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: a capacity-2 in-order queue models the register,
// the driver pushes accepted beats, an independent monitor compares and pops on consume.
module tb_if_id_skid_reg;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int CW = 32;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   if_id_skid_reg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef IFID_PERF_CNT_EN
   logic [CW-1:0] stall_cnt, flush_cnt;
`endif

   if_id_skid_reg #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NOP_INSTR(NOP), .CNT_WIDTH(CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef IFID_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   beat_t   exp_q[$];
   int      n_total = 0;
   int      n_pass  = 0;
   bit      mon_en  = 1'b0;
   logic [31:0] pc_ctr = 32'h1000;
   logic [CW-1:0] m_stall = '0;
   logic [CW-1:0] m_flush = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.InstrF    = '0;
      bus.PCF       = '0;
      bus.PCPlus4F  = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   // One cycle of stimulus; the model accepts whenever it holds fewer than two beats.
   task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic ordy);
      logic  acc;
      beat_t e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.InstrF    = $urandom;
      bus.PCF       = pc;
      bus.PCPlus4F  = pc + 32'd4;
      bus.flush     = fl;
      bus.out_ready = ordy;
      acc = v && (exp_q.size() < 2);
      e   = '{bus.InstrF, pc, pc + 32'd4};
      @(posedge clk);
      #1;
      if (fl) exp_q.delete();
      else if (acc) exp_q.push_back(e);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_InstrD",    64'(bus.InstrD),    64'(NOP));
      chk("rst_PCD",       64'(bus.PCD),       64'd0);
      chk("rst_PCPlus4D",  64'(bus.PCPlus4D),  64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef IFID_PERF_CNT_EN
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
      exp_q.delete();
      m_stall = '0;
      m_flush = '0;
      @(negedge clk);
      idle_inputs();
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
   endtask

   // Monitor: handshake and visible data checked every cycle, queue head popped on consume.
   initial begin
      bit    mv;
      beat_t h;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            mv = (exp_q.size() > 0);
            chk("in_ready",  64'(bus.in_ready),  64'(exp_q.size() < 2));
            chk("out_valid", 64'(bus.out_valid), 64'(mv));
            if (mv) begin
               h = exp_q[0];
               chk("InstrD",   64'(bus.InstrD),   64'(h.instr));
               chk("PCD",      64'(bus.PCD),      64'(h.pc));
               chk("PCPlus4D", 64'(bus.PCPlus4D), 64'(h.pc4));
               if (bus.out_ready) void'(exp_q.pop_front());
            end else begin
               chk("bubble_InstrD",   64'(bus.InstrD),   64'(NOP));
               chk("bubble_PCD",      64'(bus.PCD),      64'd0);
               chk("bubble_PCPlus4D", 64'(bus.PCPlus4D), 64'd0);
            end
`ifdef IFID_PERF_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
            if (mv && !bus.out_ready && !bus.flush && m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;
            if (mv && bus.flush && m_flush != {CW{1'b1}})                    m_flush = m_flush + 1'b1;
`endif
         end
      end
   end

   initial begin
      idle_inputs();
      do_reset();

      for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 1'b0, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 1'b1);

      drive(1'b1, 32'h10, 1'b0, 1'b0);
      drive(1'b1, 32'h14, 1'b0, 1'b0);
      drive(1'b1, 32'h40, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b1);

      drive(1'b1, 32'h20, 1'b0, 1'b0);
      drive(1'b1, 32'h24, 1'b0, 1'b0);
      drive(1'b1, 32'h18, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      drive(1'b1, 32'h28, 1'b0, 1'b0);
      drive(1'b1, 32'h2c, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b1);

      drive(1'b1, 32'h30, 1'b0, 1'b1);
      drive(1'b1, 32'h34, 1'b0, 1'b1);
      drive(1'b1, 32'h38, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 1'b1);

      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         drive(1'($urandom_range(0, 9) < 7), pc_ctr, 1'($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 9) < 6));
         pc_ctr = pc_ctr + 32'd4;
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b1);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
